// File: rtl/brisc_pkg.sv
// brisc_pkg: shared core widths and the writeback request record.
package brisc_pkg;
   localparam int XLEN = 32;
   localparam int REG_BITS = 5;
   localparam int WB_FIFO_DEPTH = 2;
   typedef struct packed {
      logic [REG_BITS-1:0] rd;
      logic [XLEN-1:0]     data;
   } wb_req_t;
endpackage

// File: rtl/wb_result_fifo.sv
// wb_result_fifo: small synchronous FIFO for multiply/divide results, exposing per-entry rd for hazard checks.
module wb_result_fifo
   import brisc_pkg::*;
#(
   parameter int DEPTH = WB_FIFO_DEPTH
) (
   input  logic                          clk,
   input  logic                          reset,
   input  logic                          push,
   input  wb_req_t                       push_req,
   input  logic                          pop,
   output logic                          full,
   output logic                          empty,
   output wb_req_t                       head,
   output logic [DEPTH-1:0]              entry_valid,
   output logic [DEPTH-1:0][REG_BITS-1:0] entry_rd
);
   localparam int AW = $clog2(DEPTH);
   logic [AW-1:0] wr_ptr, rd_ptr;
   logic          do_push, do_pop;
   wb_req_t       mem [DEPTH];
   assign full    = &entry_valid;
   assign empty   = ~|entry_valid;
   assign do_push = push && !full;
   assign do_pop  = pop && !empty;
   assign head    = mem[rd_ptr];
   // wr_ptr == rd_ptr only when empty or full, so the two valid-bit updates never collide
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         wr_ptr      <= '0;
         rd_ptr      <= '0;
         entry_valid <= '0;
      end else begin
         if (do_push) begin
            wr_ptr              <= wr_ptr + 1'b1;
            entry_valid[wr_ptr] <= 1'b1;
         end
         if (do_pop) begin
            rd_ptr              <= rd_ptr + 1'b1;
            entry_valid[rd_ptr] <= 1'b0;
         end
      end
   end
   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= push_req;
   end
   always_comb begin
      entry_rd = '0;
      for (int i = 0; i < DEPTH; i++) entry_rd[i] = mem[i].rd;
   end
endmodule

// File: rtl/rf_wb_arbiter.sv
// rf_wb_arbiter: shares the register-file write port between pipeline writeback and buffered mul/div results.
module rf_wb_arbiter
   import brisc_pkg::*;
#(
   parameter int FIFO_DEPTH   = WB_FIFO_DEPTH,
   parameter int STARVE_LIMIT = 4
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                pipe_valid_in,
   input  logic [REG_BITS-1:0] pipe_rd_in,
   input  logic [XLEN-1:0]     pipe_data_in,
   output logic                pipe_ready_out,
   input  logic                mul_valid_in,
   input  logic [REG_BITS-1:0] mul_rd_in,
   input  logic [XLEN-1:0]     mul_data_in,
   output logic                mul_ready_out,
   output logic                rf_we_out,
   output logic [REG_BITS-1:0] rf_rd_out,
   output logic [XLEN-1:0]     rf_data_out,
   output logic                grant_mul_out
);
   localparam int SW = $clog2(STARVE_LIMIT + 1);
   logic                                full, empty, hazard, grant_mul, grant_pipe, starved;
   logic [FIFO_DEPTH-1:0]               entry_valid, rd_hit;
   logic [FIFO_DEPTH-1:0][REG_BITS-1:0] entry_rd;
   logic [SW-1:0]                       starve_cnt;
   wb_req_t                             head, mul_req, pipe_req, sel;
   assign mul_req  = {mul_rd_in, mul_data_in};
   assign pipe_req = {pipe_rd_in, pipe_data_in};
   wb_result_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
      .clk         (clk),
      .reset       (reset),
      .push        (mul_valid_in && mul_ready_out),
      .push_req    (mul_req),
      .pop         (grant_mul),
      .full        (full),
      .empty       (empty),
      .head        (head),
      .entry_valid (entry_valid),
      .entry_rd    (entry_rd)
   );
   always_comb begin
      rd_hit = '0;
      for (int i = 0; i < FIFO_DEPTH; i++) rd_hit[i] = entry_valid[i] && entry_rd[i] == pipe_rd_in;
   end
   // x0 writes are discarded, so they never order against buffered results
   assign hazard         = pipe_valid_in && pipe_rd_in != '0 && |rd_hit;
   assign starved        = starve_cnt == SW'(STARVE_LIMIT);
   assign grant_mul      = !empty && (!pipe_valid_in || hazard || starved);
   assign grant_pipe     = pipe_valid_in && !grant_mul;
   assign pipe_ready_out = grant_pipe;
   assign mul_ready_out  = !full;
   assign sel            = grant_mul ? head : pipe_req;
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         starve_cnt    <= '0;
         rf_we_out     <= 1'b0;
         rf_rd_out     <= '0;
         rf_data_out   <= '0;
         grant_mul_out <= 1'b0;
      end else begin
         starve_cnt <= (empty || grant_mul) ? '0 : starved ? starve_cnt : starve_cnt + 1'b1;
         rf_we_out  <= (grant_mul || grant_pipe) && sel.rd != '0;
         if (grant_mul || grant_pipe) begin
            rf_rd_out     <= sel.rd;
            rf_data_out   <= sel.data;
            grant_mul_out <= grant_mul;
         end
      end
   end
endmodule

// File: tb/tb_rf_wb_arbiter.sv
// tb_rf_wb_arbiter: directed stimulus with a write scoreboard drained by a negedge monitor.
module tb_rf_wb_arbiter;
   import brisc_pkg::*;
   typedef struct packed {
      logic [REG_BITS-1:0] rd;
      logic [XLEN-1:0]     data;
      logic                gm;
   } exp_t;
   logic                clk, reset;
   logic                pv, mv;
   logic [REG_BITS-1:0] prd, mrd;
   logic [XLEN-1:0]     pd, md;
   logic                pipe_ready_out, mul_ready_out, rf_we_out, grant_mul_out;
   logic [REG_BITS-1:0] rf_rd_out;
   logic [XLEN-1:0]     rf_data_out;
   exp_t                exp_q[$];
   exp_t                mon_e;
   int                  n_cmp = 0;
   int                  n_bad = 0;
   rf_wb_arbiter dut (
      .clk            (clk),
      .reset          (reset),
      .pipe_valid_in  (pv),
      .pipe_rd_in     (prd),
      .pipe_data_in   (pd),
      .pipe_ready_out (pipe_ready_out),
      .mul_valid_in   (mv),
      .mul_rd_in      (mrd),
      .mul_data_in    (md),
      .mul_ready_out  (mul_ready_out),
      .rf_we_out      (rf_we_out),
      .rf_rd_out      (rf_rd_out),
      .rf_data_out    (rf_data_out),
      .grant_mul_out  (grant_mul_out)
   );
   initial clk = 1'b0;
   always #5 clk = ~clk;
   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
      n_cmp++;
      if (act !== req) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, req);
      end
   endtask
   task automatic want(input logic [4:0] rd, input logic [31:0] d, input logic gm);
      exp_q.push_back({rd, d, gm});
   endtask
   task automatic drive(input logic pvi, input logic [4:0] prdi, input logic [31:0] pdi,
                        input logic mvi, input logic [4:0] mrdi, input logic [31:0] mdi);
      @(negedge clk);
      pv = pvi; prd = prdi; pd = pdi;
      mv = mvi; mrd = mrdi; md = mdi;
      #1;
   endtask
   always @(negedge clk) begin
      if (reset && rf_we_out) begin
         if (exp_q.size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL unexpected_write: got rd=%0d data=0x%0h, expected no write", rf_rd_out, rf_data_out);
         end else begin
            mon_e = exp_q.pop_front();
            chk("wb_rd", 32'(rf_rd_out), 32'(mon_e.rd));
            chk("wb_data", rf_data_out, mon_e.data);
            chk("wb_grant_mul", 32'(grant_mul_out), 32'(mon_e.gm));
         end
      end
   end
   initial begin
      #200000;
      $display("FAIL watchdog: got timeout, expected completion");
      $fatal(1);
   end
   initial begin
      reset = 1'b1;
      pv = 0; prd = 0; pd = 0; mv = 0; mrd = 0; md = 0;
      #3 reset = 1'b0;
      #1;
      chk("rst_we", 32'(rf_we_out), 0);
      chk("rst_rd", 32'(rf_rd_out), 0);
      chk("rst_data", rf_data_out, 0);
      chk("rst_gm", 32'(grant_mul_out), 0);
      chk("rst_mul_ready", 32'(mul_ready_out), 1);
      pv = 1; #1;
      chk("rst_pipe_ready_hi", 32'(pipe_ready_out), 1);
      pv = 0; #1;
      chk("rst_pipe_ready_lo", 32'(pipe_ready_out), 0);
      repeat (2) @(negedge clk);
      reset = 1'b1;
      drive(1, 5, 'h11, 0, 0, 0);
      chk("pipe_only_ready", 32'(pipe_ready_out), 1);
      want(5, 'h11, 0);
      drive(0, 0, 0, 1, 3, 'hAA);
      chk("starve_push_ready", 32'(mul_ready_out), 1);
      for (int k = 1; k <= 4; k++) begin
         drive(1, 7, 32'('h70 + k), 0, 0, 0);
         chk("starve_pipe_grant", 32'(pipe_ready_out), 1);
         want(7, 32'('h70 + k), 0);
      end
      drive(1, 7, 'h75, 0, 0, 0);
      chk("starve_stall", 32'(pipe_ready_out), 0);
      want(3, 'hAA, 1);
      drive(1, 7, 'h75, 0, 0, 0);
      chk("starve_resume", 32'(pipe_ready_out), 1);
      want(7, 'h75, 0);
      drive(0, 0, 0, 1, 9, 'h1);
      drive(1, 9, 'h2, 0, 0, 0);
      chk("waw_stall", 32'(pipe_ready_out), 0);
      want(9, 'h1, 1);
      drive(1, 9, 'h2, 0, 0, 0);
      chk("waw_pipe", 32'(pipe_ready_out), 1);
      want(9, 'h2, 0);
      drive(1, 10, 'h100, 1, 11, 'hB1);
      chk("full_d1_pipe", 32'(pipe_ready_out), 1);
      want(10, 'h100, 0);
      drive(1, 12, 'h101, 1, 13, 'hB2);
      chk("full_d2_mul_ready", 32'(mul_ready_out), 1);
      chk("full_d2_pipe", 32'(pipe_ready_out), 1);
      want(12, 'h101, 0);
      drive(1, 14, 'h102, 1, 15, 'hB3);
      chk("full_blocked", 32'(mul_ready_out), 0);
      chk("full_d3_pipe", 32'(pipe_ready_out), 1);
      want(14, 'h102, 0);
      drive(0, 0, 0, 1, 15, 'hB3);
      chk("full_pop_cycle", 32'(mul_ready_out), 0);
      want(11, 'hB1, 1);
      drive(0, 0, 0, 1, 15, 'hB3);
      chk("full_after_pop", 32'(mul_ready_out), 1);
      want(13, 'hB2, 1);
      drive(0, 0, 0, 0, 0, 0);
      want(15, 'hB3, 1);
      drive(0, 0, 0, 0, 0, 0);
      chk("full_drained", 32'(mul_ready_out), 1);
      drive(1, 0, 'h55, 0, 0, 0);
      chk("x0_pipe_ready", 32'(pipe_ready_out), 1);
      drive(0, 0, 0, 1, 0, 'h66);
      drive(1, 0, 'h77, 0, 0, 0);
      chk("x0_no_hazard", 32'(pipe_ready_out), 1);
      drive(0, 0, 0, 0, 0, 0);
      drive(1, 22, 'hD1, 1, 21, 'hC1);
      chk("x0_popped_pipe", 32'(pipe_ready_out), 1);
      want(22, 'hD1, 0);
      drive(1, 24, 'hD2, 1, 23, 'hC2);
      chk("x0_popped", 32'(mul_ready_out), 1);
      chk("pre_reset_pipe", 32'(pipe_ready_out), 1);
      want(24, 'hD2, 0);
      drive(0, 0, 0, 0, 0, 0);
      chk("pre_reset_full", 32'(mul_ready_out), 0);
      chk("pre_reset_we", 32'(rf_we_out), 1);
      reset = 1'b0;
      #1;
      chk("mid_rst_we", 32'(rf_we_out), 0);
      chk("mid_rst_rd", 32'(rf_rd_out), 0);
      chk("mid_rst_data", rf_data_out, 0);
      chk("mid_rst_gm", 32'(grant_mul_out), 0);
      chk("mid_rst_mul_ready", 32'(mul_ready_out), 1);
      @(negedge clk);
      reset = 1'b1;
      drive(0, 0, 0, 0, 0, 0);
      drive(0, 0, 0, 0, 0, 0);
      drive(1, 21, 'hE1, 0, 0, 0);
      chk("post_reset_no_hazard", 32'(pipe_ready_out), 1);
      want(21, 'hE1, 0);
      drive(0, 0, 0, 0, 0, 0);
      drive(0, 0, 0, 0, 0, 0);
      chk("drain", 32'(exp_q.size()), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
